// File: rtl/mpu_pkg.sv
//------------------------------------------------------------------------------
// Module   : mpu_pkg
// Purpose  : Shared constants and types for the memory pool unit blocks.
//            This includes the block count, the id width and the state type
//            used by the deallocation FSM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mpu_pkg;

  localparam int BLOCK_COUNT      = 16;
  localparam int BLOCK_COUNT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ENQ   = 2'd2
  } dealloc_state_t;

  // True when a zero-extended id addresses a real bitmap entry.
  function automatic logic id_in_range(input int unsigned id, input int unsigned blocks);
    return id < blocks;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dealloc_unit_if.sv
//------------------------------------------------------------------------------
// Module   : dealloc_unit_if
// Purpose  : Groups the free-request handshake, the allocation mark and the
//            reservation-counter enqueue port of the deallocation unit.
//            The master side drives requests and marks; the slave side is
//            the deallocation unit itself.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dealloc_unit_if
  import mpu_pkg::*;
#(
  parameter int IDW = BLOCK_COUNT_BITS
);

  logic           free_req_valid;
  logic [IDW-1:0] free_block_id;
  logic           free_req_ready;
  logic           alloc_mark_valid;
  logic [IDW-1:0] alloc_mark_id;
  logic           rc_enqueue;
  logic [IDW-1:0] rc_freed_id;
  logic           rc_rdy;
  logic           rc_full;

  modport master (
    output free_req_valid, free_block_id, alloc_mark_valid, alloc_mark_id,
           rc_rdy, rc_full,
    input  free_req_ready, rc_enqueue, rc_freed_id
  );

  modport slave (
    input  free_req_valid, free_block_id, alloc_mark_valid, alloc_mark_id,
           rc_rdy, rc_full,
    output free_req_ready, rc_enqueue, rc_freed_id
  );

endinterface

`default_nettype wire

// File: rtl/alloc_bitmap.sv
//------------------------------------------------------------------------------
// Module   : alloc_bitmap
// Purpose  : Allocation bitmap (1 = allocated) with one set port, one clear
//            port and two combinational test ports. When the same entry is
//            both set and cleared in one cycle, the clear is applied first
//            and the set second, so the entry ends set. Out-of-range ids are
//            ignored on writes and test as 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alloc_bitmap
  import mpu_pkg::*;
#(
  parameter int BLOCKS = BLOCK_COUNT,
  parameter int IDW    = BLOCK_COUNT_BITS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           set_en,
  input  logic [IDW-1:0] set_id,
  input  logic           clr_en,
  input  logic [IDW-1:0] clr_id,
  input  logic [IDW-1:0] test_a_id,
  output logic           test_a_hit,
  input  logic [IDW-1:0] test_b_id,
  output logic           test_b_hit
);

  logic [BLOCKS-1:0] bits;
  logic [BLOCKS-1:0] bits_next;

  // Next bitmap: clear applied before set.
  always_comb begin
    bits_next = bits;
    if (clr_en && id_in_range(32'(clr_id), BLOCKS))
      bits_next[clr_id] = 1'b0;
    if (set_en && id_in_range(32'(set_id), BLOCKS))
      bits_next[set_id] = 1'b1;
  end

  // Bitmap storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bits <= '0;
    else     bits <= bits_next;
  end

  assign test_a_hit = id_in_range(32'(test_a_id), BLOCKS) && bits[test_a_id];
  assign test_b_hit = id_in_range(32'(test_b_id), BLOCKS) && bits[test_b_id];

endmodule

`default_nettype wire

// File: rtl/dealloc_unit.sv
//------------------------------------------------------------------------------
// Module   : dealloc_unit
// Purpose  : Accepts free requests and validates them against the allocation
//            bitmap. Valid frees are forwarded to the reservation counter, and
//            the bitmap is kept in step with marks from the malloc unit.
//            A free takes three cycles: accept (IDLE), check (CHECK) and
//            enqueue (ENQ). ENQ waits for as long as the counter is busy.
// Config   : DEALLOC_STATS_EN - builds the saturating free/error counters;
//            when undefined, free_count and err_count read 0.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dealloc_unit
  import mpu_pkg::*;
#(
  parameter int BLOCKS = BLOCK_COUNT,
  parameter int IDW    = BLOCK_COUNT_BITS
) (
  input  logic           clk,
  input  logic           rst,
  dealloc_unit_if.slave  bus,
  output logic           free_done,
  output logic           err_double_free,
  output logic           err_alloc_conflict,
  output logic [IDW:0]   alloc_count,
  output logic [15:0]    free_count,
  output logic [15:0]    err_count
);

  dealloc_state_t state;
  dealloc_state_t state_next;
  logic [IDW-1:0] held_id;
  logic           held_hit;
  logic           mark_hit;
  logic           enq_fire;
  logic           dbl_free;
  logic           mark_conflict;
  logic           set_en;

  alloc_bitmap #(
    .BLOCKS (BLOCKS),
    .IDW    (IDW)
  ) u_bitmap (
    .clk        (clk),
    .rst        (rst),
    .set_en     (set_en),
    .set_id     (bus.alloc_mark_id),
    .clr_en     (enq_fire),
    .clr_id     (held_id),
    .test_a_id  (held_id),
    .test_a_hit (held_hit),
    .test_b_id  (bus.alloc_mark_id),
    .test_b_hit (mark_hit)
  );

  // State register and latched request id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      held_id <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.free_req_valid)
        held_id <= bus.free_block_id;
    end
  end

  // Next-state logic with the enqueue and double-free strobes.
  always_comb begin
    state_next = state;
    enq_fire   = 1'b0;
    dbl_free   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.free_req_valid) state_next = CHECK;
      end
      CHECK: begin
        if (!held_hit) begin
          dbl_free   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = ENQ;
        end
      end
      ENQ: begin
        if (bus.rc_rdy && !bus.rc_full) begin
          enq_fire   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A mark on an entry that is being released this same cycle is not a
  // conflict, because the clear happens before the set.
  assign mark_conflict = bus.alloc_mark_valid && mark_hit &&
                         !(enq_fire && (held_id == bus.alloc_mark_id));
  assign set_en        = bus.alloc_mark_valid && !mark_conflict &&
                         id_in_range(32'(bus.alloc_mark_id), BLOCKS);

  assign bus.free_req_ready = (state == IDLE);
  assign bus.rc_enqueue     = enq_fire;
  assign bus.rc_freed_id    = held_id;
  assign free_done          = enq_fire;
  assign err_double_free    = dbl_free;
  assign err_alloc_conflict = mark_conflict;

  // Allocated-id count: it is clamped to the range [0, BLOCKS], and a
  // simultaneous set and clear leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_count <= '0;
    end else begin
      case ({set_en, enq_fire})
        2'b10: if (32'(alloc_count) < BLOCKS) alloc_count <= alloc_count + 1'b1;
        2'b01: if (alloc_count != '0)         alloc_count <= alloc_count - 1'b1;
        default: alloc_count <= alloc_count;
      endcase
    end
  end

`ifdef DEALLOC_STATS_EN
  logic [15:0] free_cnt;
  logic [15:0] err_cnt;
  logic [16:0] err_sum;

  assign err_sum = {1'b0, err_cnt} + {16'd0, dbl_free} + {16'd0, mark_conflict};

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (enq_fire && free_cnt != 16'hFFFF)
        free_cnt <= free_cnt + 16'd1;
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

  assign free_count = free_cnt;
  assign err_count  = err_cnt;
`else
  assign free_count = 16'd0;
  assign err_count  = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dealloc_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_dealloc_unit
// Purpose  : Directed self-checking bench for dealloc_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dealloc_unit;
  import mpu_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      free_done;
  logic                      err_double_free;
  logic                      err_alloc_conflict;
  logic [BLOCK_COUNT_BITS:0] alloc_count;
  logic [15:0]               free_count;
  logic [15:0]               err_count;

  int vectors     = 0;
  int miscompares = 0;

`ifdef DEALLOC_STATS_EN
  localparam int EXP_FREES = 1;
  localparam int EXP_ERRS  = 1;
`else
  localparam int EXP_FREES = 0;
  localparam int EXP_ERRS  = 0;
`endif

  dealloc_unit_if #(.IDW(BLOCK_COUNT_BITS)) bus();

  dealloc_unit #(
    .BLOCKS (BLOCK_COUNT),
    .IDW    (BLOCK_COUNT_BITS)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .free_done          (free_done),
    .err_double_free    (err_double_free),
    .err_alloc_conflict (err_alloc_conflict),
    .alloc_count        (alloc_count),
    .free_count         (free_count),
    .err_count          (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start a new cycle: just after the rising edge, return inputs to quiet.
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    bus.free_req_valid   = 1'b0;
    bus.free_block_id    = '0;
    bus.alloc_mark_valid = 1'b0;
    bus.alloc_mark_id    = '0;
    bus.rc_rdy           = 1'b1;
    bus.rc_full          = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    bus.free_req_valid   = 1'b0;
    bus.free_block_id    = '0;
    bus.alloc_mark_valid = 1'b0;
    bus.alloc_mark_id    = '0;
    bus.rc_rdy           = 1'b0;
    bus.rc_full          = 1'b0;

    // Reset state
    sample();
    check_vec("rst_ready",    32'(bus.free_req_ready), 1);
    check_vec("rst_enq",      32'(bus.rc_enqueue),     0);
    check_vec("rst_freed_id", 32'(bus.rc_freed_id),    0);
    check_vec("rst_count",    32'(alloc_count),        0);
    check_vec("rst_dbl",      32'(err_double_free),    0);
    check_vec("rst_free_cnt", 32'(free_count),         0);

    // Mark 3, then free 3: the enqueue happens two cycles after acceptance.
    begin_cycle(); rst = 1'b0;
    bus.alloc_mark_valid = 1'b1; bus.alloc_mark_id = 4'd3;
    sample();
    check_vec("m3_conflict", 32'(err_alloc_conflict), 0);
    begin_cycle();
    bus.free_req_valid = 1'b1; bus.free_block_id = 4'd3;
    sample();
    check_vec("f3_ready", 32'(bus.free_req_ready), 1);
    check_vec("f3_count_before", 32'(alloc_count), 1);
    begin_cycle();
    sample();
    check_vec("f3_check_ready", 32'(bus.free_req_ready), 0);
    check_vec("f3_check_enq",   32'(bus.rc_enqueue),     0);
    begin_cycle();
    sample();
    check_vec("f3_enq",       32'(bus.rc_enqueue),  1);
    check_vec("f3_freed_id",  32'(bus.rc_freed_id), 3);
    check_vec("f3_free_done", 32'(free_done),       1);
    begin_cycle();
    sample();
    check_vec("f3_count_after", 32'(alloc_count),        0);
    check_vec("f3_idle_ready",  32'(bus.free_req_ready), 1);
    check_vec("f3_idle_enq",    32'(bus.rc_enqueue),     0);

    // Free 5, which was never allocated: a double-free error.
    begin_cycle();
    bus.free_req_valid = 1'b1; bus.free_block_id = 4'd5;
    sample();
    begin_cycle();
    sample();
    check_vec("f5_dbl",     32'(err_double_free), 1);
    check_vec("f5_enq",     32'(bus.rc_enqueue),  0);
    begin_cycle();
    sample();
    check_vec("f5_ready",   32'(bus.free_req_ready), 1);
    check_vec("f5_enq_post",32'(bus.rc_enqueue),     0);
    check_vec("f5_dbl_post",32'(err_double_free),    0);
    check_vec("f5_count",   32'(alloc_count),        0);

    // Mark 2, then free 2 while the counter is full for four ENQ cycles.
    begin_cycle();
    bus.alloc_mark_valid = 1'b1; bus.alloc_mark_id = 4'd2;
    sample();
    begin_cycle();
    bus.free_req_valid = 1'b1; bus.free_block_id = 4'd2; bus.rc_full = 1'b1;
    sample();
    begin_cycle();
    bus.rc_full = 1'b1;
    sample();
    for (int i = 0; i < 4; i++) begin
      begin_cycle();
      bus.rc_full = 1'b1;
      sample();
      check_vec($sformatf("f2_hold_enq_%0d", i),   32'(bus.rc_enqueue),     0);
      check_vec($sformatf("f2_hold_ready_%0d", i), 32'(bus.free_req_ready), 0);
    end
    begin_cycle();
    sample();
    check_vec("f2_enq",      32'(bus.rc_enqueue),  1);
    check_vec("f2_freed_id", 32'(bus.rc_freed_id), 2);
    begin_cycle();
    sample();
    check_vec("f2_count", 32'(alloc_count), 0);

    // Mark 7 twice: the second mark is a conflict.
    begin_cycle();
    bus.alloc_mark_valid = 1'b1; bus.alloc_mark_id = 4'd7;
    sample();
    check_vec("m7a_conflict", 32'(err_alloc_conflict), 0);
    begin_cycle();
    bus.alloc_mark_valid = 1'b1; bus.alloc_mark_id = 4'd7;
    sample();
    check_vec("m7b_conflict", 32'(err_alloc_conflict), 1);
    begin_cycle();
    sample();
    check_vec("m7_count", 32'(alloc_count), 1);
    begin_cycle();
    bus.free_req_valid = 1'b1; bus.free_block_id = 4'd7;
    sample();
    begin_cycle(); sample();
    begin_cycle(); sample();
    check_vec("f7_enq", 32'(bus.rc_enqueue), 1);
    begin_cycle(); sample();
    check_vec("f7_count", 32'(alloc_count), 0);

    // Mark 4, then free 4 with a re-mark of 4 on the enqueue cycle.
    begin_cycle();
    bus.alloc_mark_valid = 1'b1; bus.alloc_mark_id = 4'd4;
    sample();
    begin_cycle();
    bus.free_req_valid = 1'b1; bus.free_block_id = 4'd4;
    sample();
    begin_cycle(); sample();
    begin_cycle();
    bus.alloc_mark_valid = 1'b1; bus.alloc_mark_id = 4'd4;
    sample();
    check_vec("f4_enq",      32'(bus.rc_enqueue),     1);
    check_vec("f4_conflict", 32'(err_alloc_conflict), 0);
    begin_cycle();
    bus.alloc_mark_valid = 1'b1; bus.alloc_mark_id = 4'd4;
    sample();
    check_vec("f4_count",       32'(alloc_count),        1);
    check_vec("f4_bit_still_1", 32'(err_alloc_conflict), 1);
    begin_cycle(); sample();
    check_vec("f4_count_hold", 32'(alloc_count), 1);

    // Reset asserted while waiting in ENQ abandons the free.
    begin_cycle();
    bus.alloc_mark_valid = 1'b1; bus.alloc_mark_id = 4'd9;
    sample();
    begin_cycle();
    bus.free_req_valid = 1'b1; bus.free_block_id = 4'd9; bus.rc_full = 1'b1;
    sample();
    begin_cycle(); bus.rc_full = 1'b1; sample();
    begin_cycle(); bus.rc_full = 1'b1; sample();
    check_vec("r9_enq_held", 32'(bus.rc_enqueue), 0);
    check_vec("r9_count",    32'(alloc_count),    2);
    #2 rst = 1'b1;
    #1;
    check_vec("r9_rst_ready", 32'(bus.free_req_ready), 1);
    check_vec("r9_rst_count", 32'(alloc_count),        0);
    check_vec("r9_rst_id",    32'(bus.rc_freed_id),    0);
    begin_cycle();
    sample();
    check_vec("r9_rst_enq", 32'(bus.rc_enqueue), 0);
    begin_cycle(); rst = 1'b0;
    sample();
    check_vec("r9_post_enq",   32'(bus.rc_enqueue),     0);
    check_vec("r9_post_ready", 32'(bus.free_req_ready), 1);

    // Clear of 1 and mark of 6 in the same cycle leave the count unchanged.
    begin_cycle();
    bus.alloc_mark_valid = 1'b1; bus.alloc_mark_id = 4'd1;
    sample();
    begin_cycle();
    bus.free_req_valid = 1'b1; bus.free_block_id = 4'd1;
    sample();
    begin_cycle(); sample();
    begin_cycle();
    bus.alloc_mark_valid = 1'b1; bus.alloc_mark_id = 4'd6;
    sample();
    check_vec("f1m6_enq", 32'(bus.rc_enqueue), 1);
    begin_cycle();
    bus.free_req_valid = 1'b1; bus.free_block_id = 4'd1;
    sample();
    check_vec("f1m6_count", 32'(alloc_count), 1);
    begin_cycle(); sample();
    check_vec("f1_again_dbl", 32'(err_double_free), 1);
    begin_cycle(); sample();
    check_vec("stat_free_count", 32'(free_count), EXP_FREES);
    check_vec("stat_err_count",  32'(err_count),  EXP_ERRS);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
